// File: rtl/mult_acc_stage.sv
// Frame accumulator behind the 16x16 multiplier: sums unsigned products up to in_last
// into a saturating accumulator and presents total, term count and overflow on a held handshake.
module mult_acc_stage #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 40,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic [ACC_W-1:0]   r_out_acc;
    logic [CNT_W-1:0]   r_out_count;
    logic               r_out_ovf;
    logic               r_out_valid;

    logic               w_accept;
    logic [ACC_W-1:0]   w_zext;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_ovf_nxt;

    assign in_ready  = (r_state != S_HOLD);
    assign w_accept  = in_valid && in_ready;
    assign w_zext    = {{(ACC_W-PROD_W){1'b0}}, in_product};
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_zext};

    // Once saturated the frame stays pinned at all ones, even for zero-valued terms.
    always_comb begin
        w_acc_nxt = w_zext;
        w_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
        w_ovf_nxt = 1'b0;
        if (r_state == S_ACC) begin
            if (r_ovf || w_sum[ACC_W]) begin
                w_acc_nxt = {ACC_W{1'b1}};
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_sum[ACC_W-1:0];
            end
            w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_acc   <= '0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACC: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_cnt <= w_cnt_nxt;
                        r_ovf <= w_ovf_nxt;
                        if (in_last) begin
                            r_state     <= S_HOLD;
                            r_out_acc   <= w_acc_nxt;
                            r_out_count <= w_cnt_nxt;
                            r_out_ovf   <= w_ovf_nxt;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACC;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_acc   = r_out_acc;
    assign out_count = r_out_count;
    assign out_ovf   = r_out_ovf;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Bench for mult_acc_stage: a default-width and a 33-bit instance share stimulus and are
// compared every cycle against a frame-level model (true sums, clipped per width).
module tb_mult_acc_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [31:0] in_product;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        rdy_a, vld_a, ovf_a;
    logic [39:0] acc_a;
    logic [15:0] cnt_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [32:0] acc_b;
    logic [15:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;

    // frame model: open frame sum/count, last presented result
    logic        m_pend, m_open;
    logic [63:0] m_sum, m_rsum;
    longint      m_n, m_rn;
    logic [31:0] rp;

    always #5 clk = ~clk;

    mult_acc_stage dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_product(in_product),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_a),
        .out_acc(acc_a), .out_count(cnt_a), .out_ovf(ovf_a),
        .out_valid(vld_a), .out_ready(out_ready)
    );

    mult_acc_stage #(.PROD_W(32), .ACC_W(33), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_product(in_product),
        .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_b),
        .out_acc(acc_b), .out_count(cnt_b), .out_ovf(ovf_b),
        .out_valid(vld_b), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] sat(input logic [63:0] s, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        return (s > mx) ? mx : s;
    endfunction

    function automatic logic [63:0] sat_cnt(input longint n);
        return (n > 65535) ? 64'd65535 : 64'(n);
    endfunction

    // Inputs are stable from posedge+1 through the next posedge, so at the falling
    // edge the model checks the present outputs and then applies the coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_pend = 1'b0; m_open = 1'b0; m_sum = '0; m_n = 0; m_rsum = '0; m_rn = 0;
            chk("rst_vld_a", vld_a, 0);
            chk("rst_acc_a", acc_a, 0);
            chk("rst_cnt_a", cnt_a, 0);
            chk("rst_ovf_a", ovf_a, 0);
            chk("rst_vld_b", vld_b, 0);
            chk("rst_acc_b", acc_b, 0);
        end else begin
            chk("in_ready_a", rdy_a, !m_pend);
            chk("in_ready_b", rdy_b, !m_pend);
            chk("out_valid_a", vld_a, m_pend);
            chk("out_valid_b", vld_b, m_pend);
            chk("out_acc_a", acc_a, sat(m_rsum, 40));
            chk("out_acc_b", acc_b, sat(m_rsum, 33));
            chk("out_count_a", cnt_a, sat_cnt(m_rn));
            chk("out_count_b", cnt_b, sat_cnt(m_rn));
            chk("out_ovf_a", ovf_a, m_rsum > sat(m_rsum, 40));
            chk("out_ovf_b", ovf_b, m_rsum > sat(m_rsum, 33));
            if (clear) begin
                m_pend = 1'b0; m_open = 1'b0;
            end else if (m_pend) begin
                if (out_ready) m_pend = 1'b0;
            end else if (in_valid) begin
                if (!m_open) begin
                    m_sum = 64'(in_product); m_n = 1;
                end else begin
                    m_sum = m_sum + 64'(in_product); m_n = m_n + 1;
                end
                if (in_last) begin
                    m_pend = 1'b1; m_open = 1'b0; m_rsum = m_sum; m_rn = m_n;
                end else begin
                    m_open = 1'b1;
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] p, input logic l,
                        input logic ordy, input logic clr);
        in_valid = v; in_product = p; in_last = l; out_ready = ordy; clear = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_product = '0; in_valid = 1'b0;
        in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 0, 0, 1, 0);

        // reset in the middle of a frame
        step(1, 5, 0, 1, 0);
        step(1, 7, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_vld", vld_a, 0);
        chk("midrst_acc", acc_a, 0);
        step(0, 0, 0, 1, 0);
        rst_n = 1'b1;
        step(1, 9, 1, 1, 0);
        chk("postrst_cnt", cnt_a, 1);
        chk("postrst_acc", acc_a, 9);
        step(0, 0, 0, 1, 0);

        // three-term frame crossing 32 bits
        step(1, 6, 0, 1, 0);
        step(1, 10, 0, 1, 0);
        step(1, 32'hFFFF_FFFF, 1, 1, 0);
        chk("three_vld", vld_a, 1);
        chk("three_acc", acc_a, 40'h01_0000_000F);
        chk("three_cnt", cnt_a, 3);
        chk("three_ovf", ovf_a, 0);
        step(0, 0, 0, 1, 0);
        chk("three_rdy", rdy_a, 1);

        // single-beat frame
        step(1, 32'h1234_5678, 1, 1, 0);
        chk("single_acc", acc_a, 40'h00_1234_5678);
        chk("single_cnt", cnt_a, 1);
        step(0, 0, 0, 1, 0);

        // backpressure while beats keep coming
        step(1, 3, 0, 0, 0);
        step(1, 4, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, $urandom, 1'($urandom_range(0, 1)), 0, 0);
            chk("bp_rdy", rdy_a, 0);
            chk("bp_acc", acc_a, 7);
            chk("bp_cnt", cnt_a, 2);
        end
        step(1, 50, 1, 1, 0);
        chk("bp_done_vld", vld_a, 0);
        step(1, 60, 1, 1, 0);
        chk("bp_next_acc", acc_a, 60);
        step(0, 0, 0, 1, 0);

        // saturation in the 33-bit instance
        step(1, 32'hFFFF_FFFF, 0, 1, 0);
        step(1, 32'hFFFF_FFFF, 0, 1, 0);
        step(1, 32'hFFFF_FFFF, 1, 1, 0);
        chk("sat_acc_b", acc_b, 33'h1_FFFF_FFFF);
        chk("sat_ovf_b", ovf_b, 1);
        chk("sat_cnt_b", cnt_b, 3);
        chk("nosat_acc_a", acc_a, 40'h02_FFFF_FFFD);
        step(0, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        chk("postsat_acc_b", acc_b, 1);
        chk("postsat_ovf_b", ovf_b, 0);
        step(0, 0, 0, 1, 0);

        // clear discards the frame and the simultaneous beat
        step(1, 100, 0, 1, 0);
        step(1, 200, 0, 1, 0);
        step(1, 300, 1, 1, 1);
        chk("clr_vld", vld_a, 0);
        step(0, 0, 0, 1, 0);
        chk("clr_vld2", vld_a, 0);
        step(1, 4, 1, 1, 0);
        chk("clr_next_acc", acc_a, 4);
        chk("clr_next_cnt", cnt_a, 1);

        // clear drops a presented result even with out_ready high
        step(1, 11, 1, 1, 1);
        step(0, 0, 0, 1, 0);

        // term counter saturation
        for (int i = 0; i < 65537; i++) step(1, 1, 0, 1, 0);
        step(1, 1, 1, 0, 0);
        chk("cnt_sat", cnt_a, 16'hFFFF);
        chk("cnt_sat_acc", acc_a, 40'd65538);
        step(0, 0, 0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(1'($urandom_range(0, 3) != 0), rp, 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
